pipeline_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and run-control unit for the 5-stage RSA pipeline (F/D/E/M/W).
- Generates per-stage stall/flush and EX-stage forwarding selects.
- Stretches the pipeline for a multi-cycle execute op of configurable latency.
- Owns the start/run/drain/end sequencing that gates the PC.
- Sits beside the control unit and datapath inside the processor top, and replaces the ad-hoc start/EndFlag handling in the PC control path.

---
 rtl/pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and run-control unit for the 5-stage F/D/E/M/W pipeline.
// Define HAZARD_PERF_EN to build the StallCnt/FlushCnt performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int MUL_LAT    = 4,
    parameter int DRAIN_CYC  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  HaltD,
    input  logic [REG_ADDR_W-1:0] RA1D,
    input  logic [REG_ADDR_W-1:0] RA2D,
    input  logic [REG_ADDR_W-1:0] RA1E,
    input  logic [REG_ADDR_W-1:0] RA2E,
    input  logic [REG_ADDR_W-1:0] WA3E,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic [REG_ADDR_W-1:0] WA3W,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  MulE,
    input  logic                  BranchTakenE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  Running,
    output logic                  EndFlag,
    output logic [31:0]           StallCnt,
    output logic [31:0]           FlushCnt
);

    localparam int MUL_W = $clog2(MUL_LAT) + 1;
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);
    localparam logic [MUL_W-1:0] MUL_ZERO = MUL_W'(0);
    localparam logic [MUL_W-1:0] MUL_ONE  = MUL_W'(1);
    localparam logic [MUL_W-1:0] MUL_LOAD = MUL_W'(MUL_LAT - 1);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC);
    localparam logic             MUL_MULTI = (MUL_LAT > 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic             startQ_r;
    logic [MUL_W-1:0] mulCnt_r;
    logic [DRN_W-1:0] drainCnt_r;
    logic             running_r;
    logic             endFlag_r;

    logic active_s;
    logic startRise_s;
    logic mulLoad_s;
    logic mulBusy_s;
    logic lwStall_s;
    logic haltGo_s;
    logic stallF_s, stallD_s, stallE_s;
    logic flushD_s, flushE_s, flushM_s;

    // M-stage result beats W-stage result when both target the same source
    function automatic logic [1:0] fwdSel(
        input logic                  regWriteM,
        input logic [REG_ADDR_W-1:0] wa3M,
        input logic                  regWriteW,
        input logic [REG_ADDR_W-1:0] wa3W,
        input logic [REG_ADDR_W-1:0] ra
    );
        if (regWriteM && (wa3M == ra)) begin
            return 2'b10;
        end else if (regWriteW && (wa3W == ra)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Hazard qualifiers shared by the stall/flush selection and the FSM
    always_comb begin
        active_s    = ~reset & ((state_r == RUN) | (state_r == DRAIN));
        startRise_s = start & ~startQ_r;
        mulLoad_s   = active_s & MulE & (mulCnt_r == MUL_ZERO) & MUL_MULTI;
        mulBusy_s   = active_s & ((mulCnt_r != MUL_ZERO) | mulLoad_s);
        lwStall_s   = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
    end

    // Stall/flush selection: reset/idle > mul busy > branch > load-use > drain
    always_comb begin
        stallF_s = 1'b0;
        stallD_s = 1'b0;
        stallE_s = 1'b0;
        flushD_s = 1'b0;
        flushE_s = 1'b0;
        flushM_s = 1'b0;
        if (!active_s) begin
            stallF_s = 1'b1;
            stallD_s = 1'b1;
            flushE_s = 1'b1;
        end else if (mulBusy_s) begin
            stallF_s = 1'b1;
            stallD_s = 1'b1;
            stallE_s = 1'b1;
            flushM_s = 1'b1;
        end else if (BranchTakenE) begin
            // the D instruction is wrong-path, so a coincident load-use is ignored
            flushD_s = 1'b1;
            flushE_s = 1'b1;
            stallF_s = (state_r == DRAIN);
        end else if (lwStall_s) begin
            stallF_s = 1'b1;
            stallD_s = 1'b1;
            flushE_s = 1'b1;
        end else if (state_r == DRAIN) begin
            stallF_s = 1'b1;
            flushD_s = 1'b1;
        end else begin
            stallF_s = 1'b0;
        end
    end

    // Halt leaves D only when it actually advances and is not squashed
    always_comb begin
        haltGo_s = (state_r == RUN) & ~reset & HaltD & ~stallD_s & ~BranchTakenE;
    end

    // Output drive for stalls, flushes and forwarding selects
    always_comb begin
        StallF = stallF_s;
        StallD = stallD_s;
        StallE = stallE_s;
        FlushD = flushD_s;
        FlushE = flushE_s;
        FlushM = flushM_s;
        if (reset) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end else begin
            ForwardAE = fwdSel(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
            ForwardBE = fwdSel(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
        end
    end

    // Run-control FSM with start edge detect and the multi-cycle/drain counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            startQ_r   <= 1'b0;
            mulCnt_r   <= MUL_ZERO;
            drainCnt_r <= DRN_W'(0);
            running_r  <= 1'b0;
            endFlag_r  <= 1'b0;
        end else begin
            startQ_r <= start;
            if (mulLoad_s) begin
                mulCnt_r <= MUL_LOAD;
            end else if (mulCnt_r != MUL_ZERO) begin
                mulCnt_r <= mulCnt_r - MUL_ONE;
            end else begin
                mulCnt_r <= MUL_ZERO;
            end
            case (state_r)
                IDLE, DONE: begin
                    if (startRise_s) begin
                        state_r   <= RUN;
                        running_r <= 1'b1;
                        endFlag_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (haltGo_s) begin
                        state_r    <= DRAIN;
                        drainCnt_r <= DRN_LOAD;
                    end
                end
                DRAIN: begin
                    // a multi-cycle op still in E freezes the drain countdown
                    if (mulCnt_r == MUL_ZERO) begin
                        if (drainCnt_r == DRN_ONE) begin
                            state_r   <= DONE;
                            running_r <= 1'b0;
                            endFlag_r <= 1'b1;
                        end else begin
                            drainCnt_r <= drainCnt_r - DRN_ONE;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                    endFlag_r <= 1'b0;
                end
            endcase
        end
    end

    assign Running = running_r;
    assign EndFlag = endFlag_r;

`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt_r;
    logic [31:0] flushCnt_r;
    logic        branchFlush_s;

    assign branchFlush_s = active_s & ~mulBusy_s & BranchTakenE;

    // Saturating stall/flush event counters, live only while running
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt_r <= 32'd0;
            flushCnt_r <= 32'd0;
        end else begin
            if (active_s && stallD_s && (stallCnt_r != 32'hFFFF_FFFF)) begin
                stallCnt_r <= stallCnt_r + 32'd1;
            end
            if (branchFlush_s && (flushCnt_r != 32'hFFFF_FFFF)) begin
                flushCnt_r <= flushCnt_r + 32'd1;
            end
        end
    end

    assign StallCnt = stallCnt_r;
    assign FlushCnt = flushCnt_r;
`else
    assign StallCnt = 32'd0;
    assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int AW        = 4;
    localparam int MUL_LAT   = 4;
    localparam int DRAIN_CYC = 3;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, HaltD;
    logic [AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MulE, BranchTakenE;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, Running, EndFlag;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] StallCnt, FlushCnt;
    logic StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, Running1, EndFlag1;
    logic [1:0] ForwardAE1, ForwardBE1;
    logic [31:0] StallCnt1, FlushCnt1;

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MUL_LAT(MUL_LAT), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .HaltD(HaltD),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MulE(MulE), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .Running(Running), .EndFlag(EndFlag), .StallCnt(StallCnt), .FlushCnt(FlushCnt));

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MUL_LAT(1), .DRAIN_CYC(DRAIN_CYC)) dut1 (
        .clk(clk), .reset(reset), .start(start), .HaltD(HaltD),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MulE(MulE), .BranchTakenE(BranchTakenE),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
        .Running(Running1), .EndFlag(EndFlag1), .StallCnt(StallCnt1), .FlushCnt(FlushCnt1));

    int nAssert = 0;
    int nFail   = 0;

    // reference model: 0 idle, 1 run, 2 drain, 3 done
    int     mState = 0;
    int     mMul   = 0;
    int     mDrain = 0;
    bit     mStartQ = 1'b0;
    longint mStallCnt = 0;
    longint mFlushCnt = 0;
    logic eStallF, eStallD, eStallE, eFlushD, eFlushE, eFlushM, eMulLoad, eBr;
    logic [1:0] eFwdA, eFwdB;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwdRef(input logic [AW-1:0] ra);
        if (RegWriteM && WA3M == ra) return 2'b10;
        if (RegWriteW && WA3W == ra) return 2'b01;
        return 2'b00;
    endfunction

    task automatic modelOutputs();
        bit act, drn, busy, lwc, lw, idleish;
        act      = !reset && (mState == 1 || mState == 2);
        drn      = act && mState == 2;
        eMulLoad = act && MulE && mMul == 0 && MUL_LAT > 1;
        busy     = act && (mMul > 0 || eMulLoad);
        lwc      = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
        eBr      = act && !busy && BranchTakenE;
        lw       = act && !busy && !BranchTakenE && lwc;
        idleish  = !act;
        eStallF  = idleish || busy || lw || drn;
        eStallD  = idleish || busy || lw;
        eStallE  = busy;
        eFlushD  = eBr || (drn && !busy && !lw);
        eFlushE  = idleish || eBr || lw;
        eFlushM  = busy;
        eFwdA    = reset ? 2'b00 : fwdRef(RA1E);
        eFwdB    = reset ? 2'b00 : fwdRef(RA2E);
    endtask

    task automatic modelEdge();
        bit rise;
        int oldMul;
        if (reset) begin
            mState = 0; mMul = 0; mDrain = 0; mStartQ = 1'b0;
            mStallCnt = 0; mFlushCnt = 0;
        end else begin
            rise    = start && !mStartQ;
            mStartQ = start;
            oldMul  = mMul;
            if ((mState == 1 || mState == 2) && eStallD && mStallCnt < 64'hFFFF_FFFF) mStallCnt++;
            if (eBr && mFlushCnt < 64'hFFFF_FFFF) mFlushCnt++;
            if (eMulLoad) mMul = MUL_LAT - 1;
            else if (mMul > 0) mMul--;
            case (mState)
                0, 3: if (rise) mState = 1;
                1: if (HaltD && !eStallD && !BranchTakenE) begin mState = 2; mDrain = DRAIN_CYC; end
                2: if (oldMul == 0) begin
                    if (mDrain == 1) mState = 3;
                    else mDrain--;
                end
                default: mState = 0;
            endcase
        end
    endtask

    // compare every output with the model, then advance one clock
    task automatic step();
        #1;
        modelOutputs();
        chk("hazard_ctl", {26'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM},
            {26'd0, eStallF, eStallD, eStallE, eFlushD, eFlushE, eFlushM});
        chk("forward", {28'd0, ForwardAE, ForwardBE}, {28'd0, eFwdA, eFwdB});
        chk("forward_lat1", {28'd0, ForwardAE1, ForwardBE1}, {28'd0, eFwdA, eFwdB});
        chk("run_end", {30'd0, Running, EndFlag},
            {30'd0, (mState == 1 || mState == 2) ? 1'b1 : 1'b0, (mState == 3) ? 1'b1 : 1'b0});
        chk("stall_cnt", StallCnt, PERF ? mStallCnt[31:0] : 32'd0);
        chk("flush_cnt", FlushCnt, PERF ? mFlushCnt[31:0] : 32'd0);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic clearIn();
        HaltD = 1'b0; RA1D = '0; RA2D = '0; RA1E = '0; RA2E = '0;
        WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        MemtoRegE = 1'b0; MulE = 1'b0; BranchTakenE = 1'b0;
    endtask

    initial begin
        int nDrain;
        logic [7:0] mask, mask1;
        clearIn();
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);

        // reset and idle
        #1 chk("reset_outputs", {29'd0, StallF, StallD, FlushE}, 32'd7);
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("idle_outputs", {26'd0, StallF, StallD, FlushE, FlushD, Running, EndFlag}, 32'h38);
            chk("idle_outputs_lat1", {26'd0, StallF1, StallD1, FlushE1, FlushD1, Running1, EndFlag1}, 32'h38);
            step();
        end
        start = 1'b1;
        step();
        #1 chk("start_running", {31'd0, Running}, 32'd1);

        // forwarding
        RegWriteM = 1'b1; WA3M = 4'd5; RegWriteW = 1'b1; WA3W = 4'd5; RA1E = 4'd5; RA2E = 4'd5;
        #1 chk("fwd_m_priority", {28'd0, ForwardAE, ForwardBE}, 32'hA);
        step();
        RegWriteM = 1'b0;
        #1 chk("fwd_w", {28'd0, ForwardAE, ForwardBE}, 32'h5);
        step();
        RA1E = 4'd6;
        #1 chk("fwd_rf", {30'd0, ForwardAE}, 32'd0);
        step();
        clearIn();

        // load-use for one cycle, then branch overriding it
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd3; RA2D = 4'd3;
        #1 chk("lw_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
        step();
        MemtoRegE = 1'b0; RegWriteE = 1'b0;
        #1 chk("lw_released", {31'd0, StallD}, 32'd0);
        step();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; BranchTakenE = 1'b1;
        #1 chk("branch_over_lw", {29'd0, FlushD, FlushE, StallD}, 32'd6);
        step();
        clearIn();

        // multi-cycle op
        mask = 8'd0; mask1 = 8'd0;
        MulE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            mask[i]  = StallE & FlushM;
            mask1[i] = StallE1 | FlushM1;
            step();
            MulE = 1'b0;
        end
        chk("mul_stall_window", {24'd0, mask}, 32'h0F);
        chk("mul_lat1_nostall", {24'd0, mask1}, 32'd0);

        // halt and plain drain
        HaltD = 1'b1;
        step();
        HaltD = 1'b0;
        nDrain = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (EndFlag) break;
            if (Running) begin
                nDrain++;
                chk("drain_no_fetch", {30'd0, StallF, FlushD}, 32'd3);
            end
            step();
        end
        chk("drain_cycles", nDrain, DRAIN_CYC);
        chk("done_flags", {30'd0, Running, EndFlag}, 32'd1);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        #1 chk("restart", {30'd0, Running, EndFlag}, 32'd2);

        // halt with a multi-cycle op arriving in E during drain
        HaltD = 1'b1;
        step();
        HaltD = 1'b0;
        MulE = 1'b1;
        nDrain = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (EndFlag) break;
            if (Running) nDrain++;
            step();
            MulE = 1'b0;
        end
        chk("drain_mul_cycles", nDrain, DRAIN_CYC + MUL_LAT - 1);
        chk("done_after_mul", {31'd0, EndFlag}, 32'd1);

        // reset in the middle of drain
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        HaltD = 1'b1;
        step();
        HaltD = 1'b0;
        step();
        reset = 1'b1;
        start = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("reset_mid_drain", {30'd0, Running, EndFlag}, 32'd0);
            step();
        end

        // performance counters
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd7; RA1D = 4'd7;
            step();
            clearIn();
            step();
        end
        BranchTakenE = 1'b1;
        step();
        clearIn();
        step();
        #1 chk("perf_stall", StallCnt, PERF ? 32'd2 : 32'd0);
        chk("perf_flush", FlushCnt, PERF ? 32'd1 : 32'd0);
        chk("perf_lat1", {StallCnt1[15:0], FlushCnt1[15:0]}, PERF ? 32'h0002_0001 : 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            RA1D = 4'($urandom_range(0, 3));
            RA2D = 4'($urandom_range(0, 3));
            RA1E = 4'($urandom_range(0, 3));
            RA2E = 4'($urandom_range(0, 3));
            WA3E = 4'($urandom_range(0, 3));
            WA3M = 4'($urandom_range(0, 3));
            WA3W = 4'($urandom_range(0, 3));
            RegWriteE    = ($urandom_range(0, 1) == 1);
            RegWriteM    = ($urandom_range(0, 1) == 1);
            RegWriteW    = ($urandom_range(0, 1) == 1);
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            MulE         = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            HaltD        = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            reset = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
